// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier, one ripple-carry add/shift step per clock.
// Optional macro MULT_SIGNED_EN adds the is_signed input (sign-magnitude signed multiply).

module mult_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [PW-1:0]      r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_a_op;
  logic [WIDTH-1:0]   w_b_op;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH:0]     w_carry;
  logic [PW-1:0]      w_next_prod;
  logic [PW-1:0]      w_result;

`ifdef MULT_SIGNED_EN
  logic               r_neg;
  logic               w_neg_in;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] negate_prod(input logic [PW-1:0] v);
    return ~v + PW'(1);
  endfunction

  assign w_a_op   = is_signed ? magnitude(a) : a;
  assign w_b_op   = is_signed ? magnitude(b) : b;
  assign w_neg_in = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign w_result = r_neg ? negate_prod(w_next_prod) : w_next_prod;
`else
  assign w_a_op   = a;
  assign w_b_op   = b;
  assign w_result = w_next_prod;
`endif

  // The multiplier occupies the low half of r_prod and is consumed LSB-first as it shifts out.
  assign w_addend   = r_prod[0] ? r_mcand : '0;
  assign w_carry[0] = 1'b0;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rca
    mult_fa_cell u_fa (
      .i_a (r_prod[WIDTH+gi]),
      .i_b (w_addend[gi]),
      .i_c (w_carry[gi]),
      .o_s (w_sum[gi]),
      .o_c (w_carry[gi+1])
    );
  end

  assign w_next_prod = {w_carry[WIDTH], w_sum, r_prod[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULT_SIGNED_EN
      r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= w_a_op;
            r_prod  <= {{WIDTH{1'b0}}, w_b_op};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef MULT_SIGNED_EN
            r_neg   <= w_neg_in;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_prod <= w_next_prod;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_hi    <= w_result[PW-1:WIDTH];
            r_lo    <= w_result[WIDTH-1:0];
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Bench for mult_unit (WIDTH=32): directed cases plus randomized traffic checked
// every cycle against a transaction-level model (product = a*b, ready WIDTH edges after acceptance).

module tb_mult_unit;

  localparam int W = 32;
`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         is_sg;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  mult_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .is_signed (is_sg),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic sg);
    logic [63:0] xe;
    logic [63:0] ye;
    if (sg && SIGNED_BUILD) begin
      xe = {{W{x[W-1]}}, x};
      ye = {{W{y[W-1]}}, y};
    end else begin
      xe = {{W{1'b0}}, x};
      ye = {{W{1'b0}}, y};
    end
    return xe * ye;
  endfunction

  // Transaction-level model: an accepted start yields its product W edges later;
  // starts arriving while a result is pending are ignored.
  int          m_left;
  logic [63:0] m_prod;
  logic        m_done;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_prod <= '0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_hi   <= m_prod[63:32];
        m_lo   <= m_prod[31:0];
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left <= W;
        m_prod <= ref_mul(a, b, is_sg);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, (m_left > 0));
      check("cyc_done", done, m_done);
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge: presents a start for the next edge, returns at the negedge after it.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isg);
    start = 1'b1;
    a     = ia;
    b     = ib;
    is_sg = isg;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    is_sg = 1'($urandom_range(0, 1));
  endtask

  // n counts edges with the accepting edge as edge 1.
  task automatic wait_done(output int n, output int bc);
    n  = 1;
    bc = busy ? 1 : 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isg,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input string nm);
    int n;
    int bc;
    @(negedge clk);
    launch(ia, ib, isg);
    wait_done(n, bc);
    check({nm, "_latency"}, n, 33);
    check({nm, "_busy_cycles"}, bc, 32);
    check({nm, "_hi"}, hi, ehi);
    check({nm, "_lo"}, lo, elo);
    check({nm, "_model"}, {m_hi, m_lo}, {ehi, elo});
  endtask

  initial begin
    int n;
    int bc;
    int dc;
    int first;
    int bad;
    logic [W-1:0] lo_at_done;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    is_sg = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    run_op(32'd3, 32'd5, 1'b0, 32'h0, 32'hF, "basic");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h1, "umax");
    run_op(32'h0, 32'h1234_5678, 1'b0, 32'h0, 32'h0, "zero_a");
    run_op(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, "zero_both");

    // A second start at RUN cycle 10 must be ignored.
    @(negedge clk);
    launch(32'd7, 32'd6, 1'b0);
    for (int i = 1; i < 10; i++) @(negedge clk);
    start = 1'b1;
    a     = 32'd9;
    b     = 32'd9;
    @(negedge clk);
    start      = 1'b0;
    dc         = 0;
    first      = 0;
    lo_at_done = '0;
    for (int k = 11; k < 60; k++) begin
      if (done) begin
        dc++;
        if (first == 0) begin
          first      = k;
          lo_at_done = lo;
        end
      end
      @(negedge clk);
    end
    check("ignore_done_count", dc, 1);
    check("ignore_done_edge", first, 33);
    check("ignore_lo", lo_at_done, 32'd42);

    // Back-to-back: start held in the DONE cycle; old result visible until the new done.
    run_op(32'd5, 32'd7, 1'b0, 32'h0, 32'd35, "b2b_first");
    launch(32'd2, 32'd2, 1'b0);
    n   = 1;
    bad = 0;
    while (!done && n < 100) begin
      if (lo !== 32'd35) bad++;
      @(negedge clk);
      n++;
    end
    check("b2b_hold", bad, 0);
    check("b2b_latency", n, 33);
    check("b2b_lo", lo, 32'd4);

    // Asynchronous reset between edges at RUN cycle 10.
    @(negedge clk);
    launch(32'd11, 32'd13, 1'b0);
    for (int i = 1; i < 10; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    #1 rst = 1'b0;
    dc = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("arst_no_done", dc, 0);
    run_op(32'd4, 32'd4, 1'b0, 32'h0, 32'd16, "post_rst");

`ifdef MULT_SIGNED_EN
    run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "sgn_neg");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h1, "sgn_pos");
    run_op(32'h8000_0000, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, "sgn_min");
`endif

    // Randomized traffic, including starts during RUN and in the DONE cycle.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      a     = pick();
      b     = pick();
      is_sg = SIGNED_BUILD ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
